// File: rtl/verificador_porta_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | verificador_porta_pkg : FSM encodings and 2-input truth tables   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package verificador_porta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Indexed by {a,b}: bit 0 is vector 00, bit 3 is vector 11
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/verificador_porta_contador_settle.sv
`default_nettype none
// +------------------------------------------------------------------+
// | contador_settle : settle-window counter, terminal count flag     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module contador_settle #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] C_LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] r_cnt;

  assign tc = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= 4'd0;
    end else if (en) begin
      // Wraps at the end of each window so the next vector starts fresh
      r_cnt <= tc ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/verificador_porta.sv
`default_nettype none
// +------------------------------------------------------------------+
// | verificador_porta : sweeps a 2-input gate, checks truth table    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module verificador_porta
  import verificador_porta_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_AND,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [2:0] r_err;
  logic [1:0] r_first;
  logic       w_tc;
  logic       w_accept;
  logic       w_sample;
  logic       w_mismatch;

  assign w_accept   = start && (r_state != ST_APPLY);
  assign w_sample   = (r_state == ST_APPLY) && w_tc;
  assign w_mismatch = (y != TRUTH_TABLE[r_idx]);

  contador_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_contador_settle (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .en  (r_state == ST_APPLY),
    .tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_next = ST_APPLY;
      ST_APPLY:         if (w_tc && (r_idx == 2'd3)) w_state_next = ST_DONE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_idx   <= 2'd0;
      r_err   <= 3'd0;
      r_first <= 2'd0;
    end else if (w_sample) begin
      if (w_mismatch) begin
        r_err <= r_err + 3'd1;
        if (r_err == 3'd0) r_first <= r_idx;
      end
      // Index parks at 3 so a,b read 11 while in DONE
      if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
    end
  end

  assign {a, b}     = r_idx;
  assign busy       = (r_state == ST_APPLY);
  assign done       = (r_state == ST_DONE);
  assign pass       = done && (r_err == 3'd0);
  assign err_count  = r_err;
  assign first_fail = r_first;

endmodule
`default_nettype wire

// File: tb/tb_verificador_porta.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_verificador_porta : directed checks for verificador_porta     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_verificador_porta;
  import verificador_porta_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic       tie1 = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic       a0, b0, y0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [1:0] ff0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] ff1;
  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] ff2;

  always #5 clk = ~clk;

  assign y0 = tie1 ? 1'b1 : (a0 & b0);

  verificador_porta #(.TRUTH_TABLE(TT_AND), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0));

  verificador_porta #(.TRUTH_TABLE(TT_OR), .SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(a1 & b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1));

  verificador_porta #(.TRUTH_TABLE(TT_AND), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .y(a2 & b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail(ff2));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs dut0 status as {busy,done,pass,err[2:0],ff[1:0]}
  function automatic logic [7:0] st0();
    return {busy0, done0, pass0, err0, ff0};
  endfunction

  initial begin
    tick(2);
    check("reset_status", st0(), 8'h00);
    check("reset_ab", {6'd0, a0, b0}, 8'd0);
    rst = 1'b0;

    // Sweep of AND against TT_AND: vector steps every 2 cycles
    start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("and_ab_%0d", k), {6'd0, a0, b0}, 8'(k / 2));
      check($sformatf("and_busy_%0d", k), {6'd0, busy0, done0}, 8'b10);
      tick();
    end
    check("and_final", st0(), 8'b0_1_1_000_00);
    check("and_ab_hold", {6'd0, a0, b0}, 8'd3);

    // AND gate against TT_OR: 01 and 10 mismatch
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(7);
    check("or_notdone", {7'd0, done1}, 8'd0);
    tick();
    check("or_final", {busy1, done1, pass1, err1, ff1}, 8'b0_1_0_010_01);

    // y tied high against TT_AND: 00,01,10 mismatch
    tie1 = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick(8);
    check("tie1_final", st0(), 8'b0_1_0_011_00);
    tie1 = 1'b0;

    // Reset during vector 10 discards the sweep
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick(4);
    check("mid_ab", {6'd0, a0, b0}, 8'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_status", st0(), 8'h00);
    check("midrst_ab", {6'd0, a0, b0}, 8'd0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick(8);
    check("post_rst_final", st0(), 8'b0_1_1_000_00);

    // Re-start mid-sweep is ignored
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick(3);
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("restart_ab", {6'd0, a0, b0}, 8'd2);
    tick(3);
    check("restart_notdone", {6'd0, busy0, done0}, 8'b10);
    tick();
    check("restart_done", st0(), 8'b0_1_1_000_00);

    // Start in DONE clears result and re-runs
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("redo_clear", st0(), 8'b1_0_0_000_00);
    check("redo_ab", {6'd0, a0, b0}, 8'd0);
    tick(8);
    check("redo_final", st0(), 8'b0_1_1_000_00);

    // rst and start together: rst wins
    rst = 1'b1; start0 = 1'b1; tick(); rst = 1'b0; start0 = 1'b0;
    check("rst_wins", st0(), 8'h00);

    // One-cycle settle window
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s1_ab_%0d", k), {6'd0, a2, b2}, 8'(k));
      check($sformatf("s1_done_%0d", k), {7'd0, done2}, 8'd0);
      tick();
    end
    check("s1_final", {busy2, done2, pass2, err2, ff2}, 8'b0_1_1_000_00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/verificador_porta.md
# verificador_porta

Synthesizable self-checking stimulus/response engine for any 2-input combinational gate. It drives all four input vectors (00, 01, 10, 11) in order and holds each one for a settling window. At the end of each window it samples the gate output and compares it with a parameterized truth table, accumulating mismatches. It sits beside a gate instance, such as the behavioural AND, and gives an on-chip pass/fail verdict in place of a simulation-only stimulus bench.

## Interface
Parameters:
- TRUTH_TABLE, 4'b1000 (AND): expected output, indexed by {a,b}; bit 0 = vector 00, bit 3 = vector 11.
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a full sweep.
- a  out  1  gate input A (MSB of vector index).
- b  out  1  gate input B (LSB of vector index).
- y  in  1  gate output under check.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until next accepted start or rst.
- pass  out  1  valid with done; 1 iff err_count == 0.
- err_count  out  3  number of mismatching vectors, 0..4.
- first_fail  out  2  index {a,b} of the first mismatch; holds 0 when err_count == 0.

## Operation
- FSM states: IDLE, APPLY, DONE.
- Reset: state IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0; vector index and settle counter = 0.
- IDLE or DONE, start=1: go to APPLY. Vector index, settle counter, err_count, first_fail, done and pass are all cleared. busy=1.
- APPLY: {a,b} = vector index. The settle counter counts 0..SETTLE_CYCLES-1.
- When the counter is at SETTLE_CYCLES-1, y is compared with TRUTH_TABLE[index]:
  - On mismatch, err_count increments. If err_count was 0, first_fail is set to index.
  - The counter resets to 0.
  - If index < 3, index increments. If index == 3, go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). a and b hold at 11 until the next start.
- start while busy: ignored; no restart, no effect on counters.
- err_count saturation is not needed; the maximum is 4 by construction.
- rst at any cycle, including mid-APPLY: returns to IDLE with reset values on the next edge. The partial result is discarded.

## Timing
- Start accepted at edge E0: a,b=00 and busy=1 are visible after E0.
- Each vector is visible for exactly SETTLE_CYCLES cycles. y is sampled at the edge that ends its window.
- The compare of vector 3 and the DONE transition happen at edge E0+4*SETTLE_CYCLES.
- done, pass and final err_count are visible after that edge: 4*SETTLE_CYCLES cycles after the start edge. Default: 8 cycles.
- y must be stable combinationally within the window; no input synchronizer. The gate under check shares clk-domain timing.
- start and rst in the same cycle: rst wins.

## Structure
- Shared definitions file: FSM state encodings (2 bits) and named truth-table constants.
  - TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
  - Later checkers for the OR/XOR gates reuse these.
- One sub-module: contador_settle, a loadable up-counter with a terminal-count flag at SETTLE_CYCLES-1 and synchronous clear. Top contains the FSM, vector index, and compare/accumulate logic.

## Test plan
- TRUTH_TABLE=TT_AND, DUT=behavioural AND, SETTLE_CYCLES=2, start pulse -> a,b step 00,01,10,11 every 2 cycles; done=1 after 8 cycles; pass=1, err_count=0, first_fail=0.
- TRUTH_TABLE=TT_OR, DUT=AND -> mismatches at 01 and 10; err_count=2, first_fail=1, pass=0.
- DUT replaced by y tied 1, TRUTH_TABLE=TT_AND -> err_count=3, first_fail=0, pass=0.
- rst asserted while vector 10 is applied -> next cycle all outputs at reset values, state IDLE. A new start gives a full clean sweep with pass=1.
- start re-pulsed mid-sweep -> ignored, and done still lands 8 cycles after the original start. start pulsed in DONE -> done/pass/err_count clear and the sweep repeats.
- SETTLE_CYCLES=1 -> each vector held 1 cycle; done visible 4 cycles after start; AND result pass=1.
